uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte-buffering stage directly upstream of the TX_RX serial transmitter.
- Accepts bytes from a producer over a valid/ready handshake and stores them in an internal FIFO.
- Presents one byte at a time to the transmitter on tx_data/tx_start, then waits for the transmitter's transmit_done before launching the next byte.
- Decouples bursty producers from the slow serial line; never drops an accepted byte.

Parameters:
DATA_W, 8, byte width; matches the TX_RX data port.
DEPTH, 16, FIFO entries; must be a power of two, at least 2.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  DATA_W  producer byte.
in_valid  input  1  producer byte valid.
in_ready  output  1  feeder can accept; equals !full.
tx_data  output  DATA_W  byte to transmitter (drives Raw_data).
tx_start  output  1  transmit request (drives start).
tx_done  input  1  transmitter transmit_done; may be a pulse or a held level.
count  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
empty  output  1  count==0.
full  output  1  count==DEPTH.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst=1), all cleared immediately:
  - Pointers and count = 0, so empty=1, full=0, in_ready=1.
  - tx_start=0, tx_data=0, busy=0.
  - FSM = IDLE; tx_done edge register = 0.
- Reset mid-transfer: any in-flight byte and all queued bytes are discarded, and tx_start drops asynchronously.
- Push: occurs on a clk edge with in_valid && in_ready.
  - Write pointer wraps modulo DEPTH; count increments.
  - When full, in_ready=0 and in_valid is ignored; no overflow write ever occurs.
  - Even if a pop happens in the same cycle, in_ready is still 0 while full (no push-through at full).
- Pop: only performed by the FSM in IDLE when !empty.
  - Read pointer wraps modulo DEPTH.
  - Pop and push in the same cycle leave count unchanged.
- tx_done edge detection: register tx_done_q each cycle; done_evt = tx_done && !tx_done_q. Only done_evt advances the FSM, so a held-high tx_done completes exactly one byte.
- FSM states and transitions:
  - IDLE: if !empty then pop the head into tx_data, set tx_start=1, go to SEND. Otherwise stay, with tx_start=0.
  - SEND: hold tx_start=1 and tx_data stable. On done_evt, set tx_start=0 and go to GAP.
  - GAP: tx_start=0 for exactly one cycle so the transmitter sees a fresh start; go to IDLE.
    - If tx_done is still high in GAP/IDLE, the next byte is still launched. A further done_evt requires tx_done to fall and rise again.
- Latency:
  - A byte pushed at edge N into an empty, idle feeder gives empty=0 after edge N.
  - tx_start=1 with the valid tx_data follows after edge N+1.
  - Back-to-back bytes: with done_evt detected at edge M, tx_start=0 after M, GAP holds through M+1, and tx_start=1 with the new byte after edge M+2 (if !empty).
- tx_data keeps the last transmitted byte in IDLE/GAP; it updates only on pop.
- done_evt in IDLE or GAP is ignored (spurious completion).
- busy=1 in SEND and GAP.

Decomposition:
- Package uart_pkg holds:
  - DATA_W default constant.
  - feeder_state_t enum {IDLE, SEND, GAP}.
- Sub-module sync_fifo (DATA_W, DEPTH) provides the storage array, pointers, count, full and empty, with push/pop inputs.
- uart_tx_feeder contains only the FSM, the edge detector and the glue.

Test Plan:
1. Single byte: reset, then push 0x5A once.
   - tx_start rises 2 edges after the push with tx_data=0x5A.
   - Pulse tx_done for 1 cycle: tx_start falls, busy=0 two cycles later, empty=1.
2. Fill to full: with tx_done held 0, push 17 bytes 0x01..0x11.
   - The first byte is popped into SEND, so 16 more are accepted (count=16, full=1).
   - in_ready=0 at the 18th attempt; byte 0x11 is accepted only if popped space allowed it; the order check confirms no loss or duplication.
3. FIFO order and wrap: push 40 random bytes in the range 10..200 while an auto-responder pulses tx_done 20 cycles after each tx_start rise.
   - tx_data sequence equals the push order exactly.
   - Pointers wrap at least twice.
4. Level-held tx_done: tx_done held high for 10 cycles during SEND with 3 bytes queued.
   - Exactly one byte completes; the next byte stays in SEND until tx_done toggles low then high.
5. Simultaneous push/pop: push a byte on the exact cycle IDLE pops with count=1.
   - count stays 1; the new byte transmits next.
6. Reset mid-SEND: assert rst between edges with 5 bytes queued.
   - tx_start=0 immediately, count=0, empty=1.
   - After release, a pushed 0xA5 transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the UART TX feeder
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; caller gates push/pop
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers producer bytes and hands them one at a time to the serial transmitter
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              busy
);
  feeder_state_t     r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_done_q;

  logic              w_push;
  logic              w_pop;
  logic              w_done_evt;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  // No push-through at full, even when the FSM pops in the same cycle.
  assign w_push     = in_valid && !w_full;
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_done_evt = tx_done && !r_done_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_done_q   <= 1'b0;
    end else begin
      r_done_q <= tx_done;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_state    <= SEND;
          end else begin
            r_tx_start <= 1'b0;
          end
        end
        SEND: begin
          if (w_done_evt) begin
            r_tx_start <= 1'b0;
            r_state    <= GAP;
          end
        end
        GAP: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = !w_full;
  assign full     = w_full;
  assign empty    = w_empty;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed, table-driven bench for uart_tx_feeder
module tb_uart_tx_feeder;
  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       busy;

  logic       manual_done;
  logic       auto_done;
  logic       auto_en;
  logic       prev_start;
  int         timer;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  int n_checks;
  int n_errors;

  assign tx_done = manual_done | auto_done;

  uart_tx_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: records each launched byte, pulses done 20 cycles later.
  always @(negedge clk) begin
    if (!auto_en) begin
      timer     = 0;
      auto_done = 1'b0;
    end else if (tx_start && !prev_start) begin
      got.push_back(tx_data);
      timer = 20;
    end else if (timer > 0) begin
      timer = timer - 1;
      if (timer == 0) auto_done = 1'b1;
    end else begin
      auto_done = 1'b0;
    end
    prev_start = tx_start;
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       dn;
    logic       s;
    logic [7:0] td;
    logic [4:0] c;
    logic       b;
    logic       e;
    logic       r;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid    = 1'b0;
    in_data     = 8'h00;
    manual_done = 1'b0;
    auto_en     = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_done();
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("drain_count", 32'(got.size()), 32'(n));
    k = 0;
    while ((busy || !empty) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_idle", 32'({busy, empty}), 32'(2'b01));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    manual_done = 1'b0;
    auto_en     = 1'b0;
    prev_start  = 1'b0;
    timer       = 0;
    auto_done   = 1'b0;

    //                v     d      dn    s     td     c      b     e     r
    tbl[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h5A, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 5'd1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 5'd0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 5'd0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 5'd0, 1'b0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_count", 32'(count), 32'(0));
    check("rst_flags", 32'({empty, full, in_ready, busy}), 32'(4'b1010));
    check("rst_tx", 32'({tx_start, tx_data}), 32'(0));

    // Single byte, spurious done, simultaneous push/pop, held done in GAP.
    for (int i = 0; i < 15; i++) begin
      in_valid    = tbl[i].v;
      in_data     = tbl[i].d;
      manual_done = tbl[i].dn;
      @(negedge clk);
      check($sformatf("vec%0d.start", i), 32'(tx_start), 32'(tbl[i].s));
      check($sformatf("vec%0d.data", i), 32'(tx_data), 32'(tbl[i].td));
      check($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].c));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].b));
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].e));
      check($sformatf("vec%0d.ready", i), 32'(in_ready), 32'(tbl[i].r));
    end
    in_valid    = 1'b0;
    manual_done = 1'b0;

    // Fill to full while the first byte is held in SEND.
    do_reset();
    for (int k = 1; k <= 17; k++) push(8'(k));
    check("fill_count", 32'(count), 32'(16));
    check("fill_flags", 32'({full, in_ready}), 32'(2'b10));
    check("fill_head", 32'({tx_start, tx_data}), 32'({1'b1, 8'h01}));
    in_valid = 1'b1;
    in_data  = 8'h12;
    @(negedge clk);
    check("full_nopush", 32'(count), 32'(16));
    manual_done = 1'b1;
    @(negedge clk);
    check("full_gap", 32'({tx_start, count}), 32'({1'b0, 5'd16}));
    manual_done = 1'b0;
    @(negedge clk);
    check("full_idle", 32'({busy, count}), 32'({1'b0, 5'd16}));
    @(negedge clk);
    check("full_pop_nothrough", 32'(count), 32'(15));
    check("full_second", 32'({tx_start, tx_data}), 32'({1'b1, 8'h02}));
    in_valid = 1'b0;
    pulse_done();
    got.delete();
    auto_en = 1'b1;
    wait_got(15);
    for (int k = 0; k < 15 && k < got.size(); k++)
      check($sformatf("fill_order%0d", k), 32'(got[k]), 32'(k + 3));
    auto_en = 1'b0;

    // FIFO order and pointer wrap with the auto-responder.
    do_reset();
    got.delete();
    exp_q.delete();
    auto_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(200, 10));
      exp_q.push_back(b);
      push(b);
    end
    wait_got(40);
    for (int k = 0; k < 40 && k < got.size(); k++)
      check($sformatf("order%0d", k), 32'(got[k]), 32'(exp_q[k]));
    auto_en = 1'b0;

    // Level-held tx_done completes exactly one byte.
    do_reset();
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    check("lvl_pre", 32'({tx_start, tx_data, count}), 32'({1'b1, 8'hA1, 5'd3}));
    manual_done = 1'b1;
    repeat (10) @(negedge clk);
    check("lvl_held", 32'({tx_start, tx_data, count}), 32'({1'b1, 8'hA2, 5'd2}));
    manual_done = 1'b0;
    @(negedge clk);
    check("lvl_low", 32'({tx_start, tx_data}), 32'({1'b1, 8'hA2}));
    manual_done = 1'b1;
    @(negedge clk);
    check("lvl_rise", 32'({tx_start, busy}), 32'(2'b01));
    manual_done = 1'b0;
    repeat (2) @(negedge clk);
    check("lvl_next", 32'({tx_start, tx_data, count}), 32'({1'b1, 8'hA3, 5'd1}));

    // Asynchronous reset in the middle of SEND.
    do_reset();
    for (int k = 0; k < 6; k++) push(8'hB0 + 8'(k));
    check("mid_pre", 32'({tx_start, count}), 32'({1'b1, 5'd5}));
    #2 rst = 1'b1;
    #1;
    check("mid_async", 32'({tx_start, count, empty, busy}), 32'({1'b0, 5'd0, 1'b1, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    push(8'hA5);
    for (int k = 0; k < 10 && !tx_start; k++) @(negedge clk);
    check("mid_after", 32'({tx_start, tx_data}), 32'({1'b1, 8'hA5}));
    pulse_done();
    @(negedge clk);
    check("mid_done", 32'({busy, empty, tx_start}), 32'(3'b010));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
